// File: rtl/alu_pkg.sv
// Shared ALU definitions: sequencer state encoding and Booth recoding ops.
// Used by the Booth multiplier and the divider sequencer.
package alu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_EVAL  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        OP_NOP = 2'd0,
        OP_ADD = 2'd1,
        OP_SUB = 2'd2
    } booth_op_t;

    // Radix-2 Booth recoding of the {Q[0], q_m1} bit pair.
    function automatic booth_op_t booth_decode(input logic [1:0] pair);
        case (pair)
            2'b01:   return OP_ADD;
            2'b10:   return OP_SUB;
            default: return OP_NOP;
        endcase
    endfunction

endpackage

// File: rtl/booth_step.sv
// One Booth evaluation step: next partial-product accumulator from A, M
// and the recoded bit pair. Purely combinational.
module booth_step
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH:0] a,
    input  logic [WIDTH:0] m,
    input  logic [1:0]     pair,
    output logic [WIDTH:0] a_next
);

    always_comb begin
        a_next = a;
        case (booth_decode(pair))
            OP_ADD:  a_next = a + m;
            OP_SUB:  a_next = a - m;
            default: a_next = a;
        endcase
    end

endmodule

// File: rtl/booth_mult.sv
// Sequential signed radix-2 Booth multiplier, WIDTH x WIDTH -> 2*WIDTH.
// Start/done handshake on bgn/fin; product presented as out_hi/out_lo.
module booth_mult
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             bgn,
    input  logic [WIDTH-1:0] inbus_q,
    input  logic [WIDTH-1:0] inbus_m,
    output logic [WIDTH-1:0] out_hi,
    output logic [WIDTH-1:0] out_lo,
    output logic             fin
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    state_t          state;
    state_t          state_nx;
    logic [WIDTH:0]  a;
    logic [WIDTH:0]  m;
    logic [WIDTH:0]  a_step;
    logic [WIDTH-1:0] q;
    logic            q_m1;
    logic [CW-1:0]   cnt;

    booth_step #(.WIDTH(WIDTH)) u_step (
        .a      (a),
        .m      (m),
        .pair   ({q[0], q_m1}),
        .a_next (a_step)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:  if (bgn) state_nx = ST_EVAL;
            ST_EVAL:  state_nx = ST_SHIFT;
            ST_SHIFT: state_nx = (cnt == CNT_LAST) ? ST_DONE : ST_EVAL;
            ST_DONE:  state_nx = ST_IDLE;
            default:  state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a      <= '0;
            m      <= '0;
            q      <= '0;
            q_m1   <= 1'b0;
            cnt    <= '0;
            out_hi <= '0;
            out_lo <= '0;
            fin    <= 1'b0;
        end else begin
            fin <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bgn) begin
                        q    <= inbus_q;
                        m    <= {inbus_m[WIDTH-1], inbus_m};
                        a    <= '0;
                        q_m1 <= 1'b0;
                        cnt  <= '0;
                    end
                end
                ST_EVAL: a <= a_step;
                ST_SHIFT: begin
                    // Arithmetic shift of {A,Q,q_m1}; the guard bit A[WIDTH] carries the sign.
                    {a, q, q_m1} <= {a[WIDTH], a, q};
                    cnt          <= cnt + CW'(1);
                end
                ST_DONE: begin
                    out_hi <= a[WIDTH-1:0];
                    out_lo <= q;
                    fin    <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_booth_mult.sv
// Bench for booth_mult: cycle-level behavioural model with per-cycle compare,
// directed literal cases and a randomised operand sweep.
module tb_booth_mult;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         bgn = 1'b0;
    logic [W-1:0] inbus_q = '0;
    logic [W-1:0] inbus_m = '0;
    logic [W-1:0] out_hi;
    logic [W-1:0] out_lo;
    logic         fin;

    int total = 0;
    int bad   = 0;

    booth_mult #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .bgn     (bgn),
        .inbus_q (inbus_q),
        .inbus_m (inbus_m),
        .out_hi  (out_hi),
        .out_lo  (out_lo),
        .fin     (fin)
    );

    always #5 clk = ~clk;

    // Behavioural model: a request is accepted when the unit is not busy;
    // the product appears with fin exactly 2*W+1 edges after acceptance.
    int          cyc = 0;
    bit          busy = 0;
    int          done_at = 0;
    logic [31:0] pend = '0;
    logic [31:0] exp_prod = '0;
    bit          exp_fin = 0;

    always @(posedge clk) begin
        if (rst) begin
            busy     = 0;
            exp_prod = '0;
            exp_fin  = 0;
        end else begin
            cyc++;
            exp_fin = 0;
            if (busy && cyc == done_at) begin
                exp_fin  = 1;
                exp_prod = pend;
                busy     = 0;
            end else if (!busy && bgn) begin
                pend    = 32'(int'($signed(inbus_q)) * int'($signed(inbus_m)));
                done_at = cyc + 2 * W + 1;
                busy    = 1;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            total++;
            if (fin !== exp_fin || {out_hi, out_lo} !== exp_prod) begin
                bad++;
                $display("FAIL model_cmp t=%0t got fin=%0b prod=%08h want fin=%0b prod=%08h",
                         $time, fin, {out_hi, out_lo}, exp_fin, exp_prod);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s got=%08h want=%08h", name, act, want);
        end
    endtask

    task automatic start(input logic [W-1:0] qv, input logic [W-1:0] mv);
        @(negedge clk);
        bgn     = 1'b1;
        inbus_q = qv;
        inbus_m = mv;
        @(negedge clk);
        bgn     = 1'b0;
        inbus_q = W'($urandom);
        inbus_m = W'($urandom);
    endtask

    // Counts negedges after the start edge until fin is seen (bounded).
    task automatic wait_fin(input string name, output int n);
        n = 0;
        while (fin !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            total++;
            bad++;
            $display("FAIL %s_timeout got=no_fin want=fin_within_100", name);
        end
    endtask

    task automatic run_lit(input string name, input logic [W-1:0] qv, input logic [W-1:0] mv,
                           input logic [31:0] want);
        int n;
        start(qv, mv);
        wait_fin(name, n);
        check({name, "_lat"}, 32'(n), 32'd33);
        check({name, "_prod"}, {out_hi, out_lo}, want);
    endtask

    logic [W-1:0] corners [5] = '{16'h0000, 16'h0001, 16'hFFFF, 16'h8000, 16'h7FFF};

    initial begin
        int n;
        logic [W-1:0] qv, mv;

        repeat (3) @(negedge clk);
        check("reset_out", {out_hi, out_lo}, 32'h0);
        check("reset_fin", 32'(fin), 32'h0);
        @(negedge clk);
        #2 rst = 1'b0;

        run_lit("t1_3x5", 16'd3, 16'd5, 32'h0000_000F);
        @(negedge clk);
        check("t1_fin_pulse", 32'(fin), 32'h0);
        run_lit("t2_m7x6", 16'hFFF9, 16'd6, 32'hFFFF_FFD6);
        run_lit("t3_minxmin", 16'h8000, 16'h8000, 32'h4000_0000);
        run_lit("t3_maxxmax", 16'h7FFF, 16'h7FFF, 32'h3FFF_0001);

        // Reset in the middle of an operation
        start(16'd3, 16'd5);
        repeat (9) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("t4_rst_out", {out_hi, out_lo}, 32'h0);
        check("t4_rst_fin", 32'(fin), 32'h0);
        @(negedge clk);
        #2 rst = 1'b0;
        run_lit("t4_after_rst", 16'h0000, 16'h1234, 32'h0);

        // Requests while busy are ignored
        start(16'd2, 16'd2);
        repeat (3) @(negedge clk);
        bgn = 1'b1;
        for (int i = 0; i < 16; i++) begin
            inbus_q = W'($urandom);
            inbus_m = W'($urandom);
            @(negedge clk);
        end
        bgn = 1'b0;
        wait_fin("t5_busy", n);
        check("t5_busy_prod", {out_hi, out_lo}, 32'h0000_0004);
        // Back-to-back start during the fin cycle
        bgn     = 1'b1;
        inbus_q = 16'hFFFF;
        inbus_m = 16'hFFFF;
        @(negedge clk);
        bgn = 1'b0;
        wait_fin("t5_b2b", n);
        check("t5_b2b_lat", 32'(n), 32'd33);
        check("t5_b2b_prod", {out_hi, out_lo}, 32'h0000_0001);

        // Randomised sweep, corners mixed in
        for (int k = 0; k < 1000; k++) begin
            qv = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 4)] : W'($urandom);
            mv = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 4)] : W'($urandom);
            if (k < 25) begin
                qv = corners[k / 5];
                mv = corners[k % 5];
            end
            start(qv, mv);
            if ($urandom_range(0, 3) == 0) begin
                bgn = 1'b1;
                repeat ($urandom_range(1, 20)) @(negedge clk);
                bgn = 1'b0;
            end
            wait_fin("sweep", n);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
